// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes, datapath select values and trap causes.
package cu_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWr, StRdWb,
    StExecR, StExecI, StAluWb, StBranch, StJal, StTrap
  } state_e;

  // Which rule the ALU decoder applies to funct3/funct7_5.
  typedef enum logic [1:0] {OpClsAdd, OpClsSub, OpClsR, OpClsI} op_cls_e;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  localparam logic [1:0] SrcAPc  = 2'd0;
  localparam logic [1:0] SrcARs1 = 2'd1;
  localparam logic [1:0] SrcBRs2 = 2'd0;
  localparam logic [1:0] SrcBImm = 2'd1;
  localparam logic [1:0] SrcB4   = 2'd2;
  localparam logic [1:0] ResAlu  = 2'd0;
  localparam logic [1:0] ResMem  = 2'd1;
  localparam logic [1:0] ResPc4  = 2'd2;

  localparam logic [1:0] CauseNone       = 2'd0;
  localparam logic [1:0] CauseIllegal    = 2'd1;
  localparam logic [1:0] CauseMemTimeout = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from funct3/funct7_5 and the operation class
// requested by the control FSM.
module alu_decoder
  import cu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7_5,
  input  logic [1:0]            i_op_cls,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl
);

  logic [3:0] w_code;

  always_comb begin
    w_code = AluAdd;
    case (i_op_cls)
      OpClsSub: w_code = AluSub;
      OpClsR, OpClsI: begin
        case (i_funct3)
          // Immediate forms have no SUBI: bit 30 is immediate data there.
          3'b000:  w_code = (i_op_cls == OpClsR && i_funct7_5) ? AluSub : AluAdd;
          3'b001:  w_code = AluSll;
          3'b010:  w_code = AluSlt;
          3'b011:  w_code = AluSltu;
          3'b100:  w_code = AluXor;
          3'b101:  w_code = i_funct7_5 ? AluSra : AluSrl;
          3'b110:  w_code = AluOr;
          default: w_code = AluAnd;
        endcase
      end
      default: w_code = AluAdd;
    endcase
  end

  assign o_alu_ctrl = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle RV32I control unit: Moore FSM with a memory wait watchdog and a
// sticky trap state left only through reset.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7_5,
  input  logic                  i_zero,
  input  logic                  i_mem_ready,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic                  o_ir_write,
  output logic                  o_pc_write,
  output logic                  o_reg_write,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic [1:0]            o_result_src,
  output logic                  o_trap,
  output logic [1:0]            o_trap_cause,
  output logic [3:0]            o_state_dbg
);

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e                r_state, w_state_nxt;
  logic [7:0]            r_wait_cnt, w_wait_cnt_nxt;
  logic [1:0]            r_cause, w_cause_nxt;
  op_cls_e               w_op_cls;
  logic [ALU_CTRL_W-1:0] w_alu_ctrl;
  logic                  w_in_wait, w_timeout;

  assign w_op_cls = (r_state == StExecR)  ? OpClsR :
                    (r_state == StExecI)  ? OpClsI :
                    (r_state == StBranch) ? OpClsSub : OpClsAdd;

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .i_funct3   (i_funct3),
    .i_funct7_5 (i_funct7_5),
    .i_op_cls   (w_op_cls),
    .o_alu_ctrl (w_alu_ctrl)
  );

  assign w_in_wait = r_state inside {StFetch, StMemRd, StMemWr};
  // Checked one cycle early so a trap follows exactly MEM_TIMEOUT idle cycles.
  assign w_timeout = w_in_wait && !i_mem_ready && (r_wait_cnt >= TimeoutLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StFetch;
      r_wait_cnt <= '0;
      r_cause    <= CauseNone;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_cause    <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cause_nxt  = r_cause;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = SrcAPc;
    o_alu_src_b  = SrcBRs2;
    o_alu_ctrl   = w_alu_ctrl;
    o_result_src = ResAlu;
    o_trap       = 1'b0;
    o_trap_cause = r_cause;
    o_state_dbg  = r_state;

    unique case (r_state)
      StFetch: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = SrcB4;
        if (i_mem_ready) begin
          o_ir_write  = 1'b1;
          o_pc_write  = 1'b1;
          w_state_nxt = StDecode;
        end
      end
      StDecode: begin
        case (i_opcode)
          OpcLoad, OpcStore: w_state_nxt = StMemAddr;
          OpcOp:             w_state_nxt = StExecR;
          OpcOpImm:          w_state_nxt = StExecI;
          OpcBranch:         w_state_nxt = StBranch;
          OpcJal:            w_state_nxt = StJal;
          default: begin
            w_state_nxt = StTrap;
            w_cause_nxt = CauseIllegal;
          end
        endcase
      end
      StMemAddr: begin
        o_alu_src_a = SrcARs1;
        o_alu_src_b = SrcBImm;
        w_state_nxt = (i_opcode == OpcStore) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) w_state_nxt = StRdWb;
      end
      StMemWr: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ready) w_state_nxt = StFetch;
      end
      StRdWb: begin
        o_reg_write  = 1'b1;
        o_result_src = ResMem;
        w_state_nxt  = StFetch;
      end
      StExecR: begin
        o_alu_src_a = SrcARs1;
        w_state_nxt = StAluWb;
      end
      StExecI: begin
        o_alu_src_a = SrcARs1;
        o_alu_src_b = SrcBImm;
        w_state_nxt = StAluWb;
      end
      StAluWb: begin
        o_reg_write = 1'b1;
        w_state_nxt = StFetch;
      end
      StBranch: begin
        o_alu_src_a = SrcARs1;
        o_pc_write  = (i_funct3 == 3'b000 && i_zero) || (i_funct3 == 3'b001 && !i_zero);
        w_state_nxt = StFetch;
      end
      StJal: begin
        o_reg_write  = 1'b1;
        o_pc_write   = 1'b1;
        o_result_src = ResPc4;
        w_state_nxt  = StFetch;
      end
      StTrap: o_trap = 1'b1;
      default: w_state_nxt = StFetch;
    endcase

    if (w_timeout) begin
      w_state_nxt = StTrap;
      w_cause_nxt = CauseMemTimeout;
    end

    w_wait_cnt_nxt = r_wait_cnt;
    if (w_state_nxt != r_state && (w_state_nxt inside {StFetch, StMemRd, StMemWr})) begin
      w_wait_cnt_nxt = '0;
    end else if (w_in_wait && !i_mem_ready && r_wait_cnt != 8'hFF) begin
      w_wait_cnt_nxt = r_wait_cnt + 8'd1;
    end

    // Outputs follow reset asynchronously, not just from the next edge.
    if (!i_rst_n) begin
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_reg_write  = 1'b0;
      o_alu_src_a  = SrcAPc;
      o_alu_src_b  = SrcBRs2;
      o_alu_ctrl   = '0;
      o_result_src = ResAlu;
      o_trap       = 1'b0;
      o_trap_cause = CauseNone;
      o_state_dbg  = StFetch;
    end
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: decode table, hand-written multi-cycle corner cases and
// random instruction streams checked against an instruction-level sequence model.
module tb_multicycle_cu;
  import cu_pkg::*;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src, trap_cause;
  logic [3:0] alu_ctrl, state_dbg;
  logic [21:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_cu #(.ALU_CTRL_W(4), .MEM_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7_5(funct7_5), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_ir_write(ir_write),
    .o_pc_write(pc_write), .o_reg_write(reg_write), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_alu_ctrl(alu_ctrl), .o_result_src(result_src),
    .o_trap(trap), .o_trap_cause(trap_cause), .o_state_dbg(state_dbg)
  );

  assign obs = {mem_req, mem_we, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
                alu_ctrl, result_src, trap, trap_cause, state_dbg};

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 check("reset_outputs_zero", obs, '0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- instruction-level reference model ----------------
  typedef struct {
    logic        rdy;
    logic [21:0] e;
  } cyc_t;

  cyc_t q[$];
  bit   trapped;

  task automatic push(input logic rdy, input state_e st, input logic mreq, input logic mwe,
                      input logic irw, input logic pcw, input logic rw, input logic [1:0] asa,
                      input logic [1:0] asb, input logic [3:0] alu, input logic [1:0] rs,
                      input logic [1:0] cause);
    cyc_t c;
    c.rdy = rdy;
    c.e   = {mreq, mwe, irw, pcw, rw, asa, asb, alu, rs, logic'(st == StTrap), cause, 4'(st)};
    q.push_back(c);
  endtask

  task automatic push_trap(input logic [1:0] cause);
    trapped = 1;
    repeat (3) push(rbit(), StTrap, 0, 0, 0, 0, 0, 0, 0, 0, 0, cause);
  endtask

  // d idle cycles then a ready cycle, or a trap once TO idle cycles have passed.
  task automatic mem_phase(input state_e st, input logic we, input int d);
    logic f;
    f = (st == StFetch);
    for (int i = 0; i < d && i < int'(TO); i++)
      push(0, st, 1, we, 0, 0, 0, 0, f ? 2'd2 : 2'd0, 0, 0, 0);
    if (d >= int'(TO)) push_trap(CauseMemTimeout);
    else push(1, st, 1, we, f, f, 0, 0, f ? 2'd2 : 2'd0, 0, 0, 0);
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? AluSub : AluAdd;
      3'd1: return AluSll;
      3'd2: return AluSlt;
      3'd3: return AluSltu;
      3'd4: return AluXor;
      3'd5: return f7 ? AluSra : AluSrl;
      3'd6: return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int df, input int dm);
    logic taken;
    q.delete();
    trapped = 0;
    mem_phase(StFetch, 0, df);
    if (trapped) return;
    push(rbit(), StDecode, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    taken = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
    case (op)
      OpcLoad: begin
        push(rbit(), StMemAddr, 0, 0, 0, 0, 0, 1, 1, AluAdd, 0, 0);
        mem_phase(StMemRd, 0, dm);
        if (!trapped) push(rbit(), StRdWb, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      end
      OpcStore: begin
        push(rbit(), StMemAddr, 0, 0, 0, 0, 0, 1, 1, AluAdd, 0, 0);
        mem_phase(StMemWr, 1, dm);
      end
      OpcOp: begin
        push(rbit(), StExecR, 0, 0, 0, 0, 0, 1, 0, ref_alu(f3, f7, 1), 0, 0);
        push(rbit(), StAluWb, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      OpcOpImm: begin
        push(rbit(), StExecI, 0, 0, 0, 0, 0, 1, 1, ref_alu(f3, f7, 0), 0, 0);
        push(rbit(), StAluWb, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      OpcBranch: push(rbit(), StBranch, 0, 0, 0, taken, 0, 1, 0, AluSub, 0, 0);
      OpcJal:    push(rbit(), StJal, 0, 0, 0, 1, 1, 0, 0, 0, 2, 0);
      default:   push_trap(CauseIllegal);
    endcase
  endtask

  task automatic run_queue(input string tag);
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      #1 check($sformatf("%s_cyc%0d", tag, i), obs, q[i].e);
      tick();
    end
  endtask

  // ---------------- decode table ----------------
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    state_e     st;
    logic [3:0] alu;
    logic       pcw;
    logic       rw;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [6:0] ops[6];
    int n;
    bit seen;
    state_e seq[4];

    vt.push_back('{OpcOp,     3'd0, 1'b0, 1'b0, StExecR,   AluAdd,  1'b0, 1'b0});
    vt.push_back('{OpcOp,     3'd0, 1'b1, 1'b0, StExecR,   AluSub,  1'b0, 1'b0});
    vt.push_back('{OpcOp,     3'd5, 1'b1, 1'b0, StExecR,   AluSra,  1'b0, 1'b0});
    vt.push_back('{OpcOp,     3'd5, 1'b0, 1'b0, StExecR,   AluSrl,  1'b0, 1'b0});
    vt.push_back('{OpcOp,     3'd7, 1'b0, 1'b0, StExecR,   AluAnd,  1'b0, 1'b0});
    vt.push_back('{OpcOpImm,  3'd0, 1'b1, 1'b0, StExecI,   AluAdd,  1'b0, 1'b0});
    vt.push_back('{OpcOpImm,  3'd5, 1'b1, 1'b0, StExecI,   AluSra,  1'b0, 1'b0});
    vt.push_back('{OpcOpImm,  3'd2, 1'b0, 1'b0, StExecI,   AluSlt,  1'b0, 1'b0});
    vt.push_back('{OpcOpImm,  3'd3, 1'b1, 1'b0, StExecI,   AluSltu, 1'b0, 1'b0});
    vt.push_back('{OpcBranch, 3'd0, 1'b0, 1'b1, StBranch,  AluSub,  1'b1, 1'b0});
    vt.push_back('{OpcBranch, 3'd0, 1'b0, 1'b0, StBranch,  AluSub,  1'b0, 1'b0});
    vt.push_back('{OpcBranch, 3'd1, 1'b0, 1'b1, StBranch,  AluSub,  1'b0, 1'b0});
    vt.push_back('{OpcBranch, 3'd1, 1'b0, 1'b0, StBranch,  AluSub,  1'b1, 1'b0});
    vt.push_back('{OpcJal,    3'd0, 1'b0, 1'b0, StJal,     AluAdd,  1'b1, 1'b1});
    vt.push_back('{OpcLoad,   3'd2, 1'b0, 1'b0, StMemAddr, AluAdd,  1'b0, 1'b0});
    vt.push_back('{OpcStore,  3'd2, 1'b0, 1'b0, StMemAddr, AluAdd,  1'b0, 1'b0});
    vt.push_back('{7'h7F,     3'd0, 1'b0, 1'b0, StTrap,    AluAdd,  1'b0, 1'b0});

    do_reset();

    foreach (vt[i]) begin
      do_reset();
      opcode = vt[i].op; funct3 = vt[i].f3; funct7_5 = vt[i].f7; zero = vt[i].z;
      mem_ready = 1'b1;
      tick();
      tick();
      #1 check($sformatf("table%0d", i), {state_dbg, alu_ctrl, pc_write, reg_write},
               {4'(vt[i].st), vt[i].alu, vt[i].pcw, vt[i].rw});
    end

    // R-type ADD with zero-latency memory: four states, write-back only in the last.
    do_reset();
    opcode = OpcOp; funct3 = 3'd0; funct7_5 = 1'b0; mem_ready = 1'b1;
    seq = '{StFetch, StDecode, StExecR, StAluWb};
    for (int k = 0; k < 4; k++) begin
      #1 check_v($sformatf("radd_state%0d", k), int'(state_dbg), int'(seq[k]));
      check_v($sformatf("radd_regw%0d", k), int'(reg_write), (k == 3) ? 1 : 0);
      tick();
    end

    // LOAD whose data arrives on the third MEM_RD cycle.
    do_reset();
    opcode = OpcLoad; mem_ready = 1'b1;
    tick();
    n = 0;
    seen = 0;
    while (n < 20) begin
      mem_ready = (n == 2 || n == 3) ? 1'b0 : 1'b1;
      #1;
      if (state_dbg == 4'(StFetch)) break;
      if (state_dbg == 4'(StRdWb)) begin
        seen = 1;
        check_v("load_rdwb_result_src", int'(result_src), 1);
      end
      n++;
      tick();
    end
    check_v("load_nonfetch_cycles", n, 6);
    check_v("load_rdwb_seen", int'(seen), 1);

    // Illegal opcode: trap is sticky and memory stays idle whatever mem_ready does.
    do_reset();
    opcode = 7'b0000000; mem_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 20; k++) begin
      mem_ready = rbit();
      #1 check($sformatf("illegal_trap%0d", k), {20'd0, mem_req, trap},
               {20'd0, 1'b0, 1'b1});
      check_v($sformatf("illegal_cause%0d", k), int'(trap_cause), 1);
      tick();
    end

    // Fetch never completes: TO idle cycles, then memory timeout trap.
    do_reset();
    opcode = OpcOp; mem_ready = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      #1 check($sformatf("timeout_wait%0d", k), {18'd0, state_dbg}, {18'd0, 4'(StFetch)});
      tick();
    end
    #1 check("timeout_trap", {17'd0, trap, trap_cause, mem_req, pc_write},
             {17'd0, 1'b1, CauseMemTimeout, 1'b0, 1'b0});
    mem_ready = 1'b1;
    tick();
    #1 check_v("timeout_sticky", int'(state_dbg), int'(StTrap));
    tick();

    // Reset pulsed in the middle of a store.
    do_reset();
    opcode = OpcStore; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1 check("store_in_memwr", {16'd0, mem_req, mem_we, state_dbg},
             {16'd0, 1'b1, 1'b1, 4'(StMemWr)});
    #2 rst_n = 1'b0;
    #1 check("store_async_reset", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("store_release", {17'd0, mem_req, state_dbg}, {17'd0, 1'b1, 4'(StFetch)});
    tick();
    #1 check_v("store_after_edge", int'(state_dbg), int'(StFetch));
    @(negedge clk);

    // Boundary: fetch ready arrives on the very cycle the watchdog would fire.
    do_reset();
    opcode = OpcOp; funct3 = 3'd4; funct7_5 = 1'b0; zero = 1'b0;
    model(opcode, funct3, funct7_5, zero, int'(TO) - 1, 0);
    run_queue("late_ready");

    // Random instruction stream.
    ops = '{OpcLoad, OpcStore, OpcOp, OpcOpImm, OpcBranch, OpcJal};
    do_reset();
    for (int it = 0; it < 150; it++) begin
      int sel, df, dm;
      sel = $urandom_range(0, 7);
      opcode = (sel < 6) ? ops[sel] : 7'($urandom_range(0, 127));
      funct3 = 3'($urandom_range(0, 7));
      funct7_5 = rbit();
      zero = rbit();
      df = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(0, TO - 1);
      dm = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(0, TO - 1);
      model(opcode, funct3, funct7_5, zero, df, dm);
      run_queue($sformatf("rand%0d", it));
      if (trapped) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter ALU_CTRL_W, default 4, width of alu_ctrl.
REQ-002 Parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ready per access, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  7  RV32I opcode of the instruction register.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7_5  input  1  instruction bit 30.
REQ-008 zero  input  1  ALU zero flag (rs1 == rs2 compare).
REQ-009 mem_ready  input  1  memory completes current request this cycle.
REQ-010 mem_req  output  1  memory request valid.
REQ-011 mem_we  output  1  request is a write.
REQ-012 ir_write, pc_write, reg_write  output  1 each  register load enables.
REQ-013 alu_src_a  output  2  0=PC, 1=rs1, 2=old PC.
REQ-014 alu_src_b  output  2  0=rs2, 1=imm, 2=const 4.
REQ-015 alu_ctrl  output  ALU_CTRL_W  ALU operation code.
REQ-016 result_src  output  2  0=ALU out, 1=mem data, 2=PC+4.
REQ-017 trap  output  1  sticky fault flag; trap_cause  output  2  1=illegal opcode, 2=memory timeout.
REQ-018 state_dbg  output  4  current state encoding.

Function
REQ-019 Outputs SHALL be Moore (state-decoded) except pc_write/ir_write in FETCH, which SHALL be gated by mem_ready.
REQ-020 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WR, RD_WB, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP.
REQ-021 FETCH: mem_req=1, mem_we=0, alu_src_a=0, alu_src_b=2; on mem_ready: ir_write=1, pc_write=1, -> DECODE; else stay.
REQ-022 DECODE (1 cycle): LOAD/STORE -> MEM_ADDR; OP -> EXEC_R; OP-IMM -> EXEC_I; BRANCH -> BRANCH; JAL -> JAL; any other opcode -> TRAP, cause 1.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=1, alu_ctrl=ADD; -> MEM_RD if LOAD, MEM_WR if STORE.
REQ-024 MEM_RD: mem_req=1 until mem_ready, then -> RD_WB; RD_WB: reg_write=1, result_src=1, -> FETCH.
REQ-025 MEM_WR: mem_req=1, mem_we=1 until mem_ready, then -> FETCH.
REQ-026 EXEC_R: alu_ctrl from funct3/funct7_5; EXEC_I: same with alu_src_b=1, funct7_5 honoured only for funct3=101; both -> ALU_WB.
REQ-027 ALU_WB: reg_write=1, result_src=0, -> FETCH.
REQ-028 BRANCH: alu_ctrl=SUB, alu_src_a=1, alu_src_b=0; pc_write=1 iff (funct3=000 and zero) or (funct3=001 and !zero); -> FETCH.
REQ-029 JAL: reg_write=1, result_src=2, pc_write=1, -> FETCH.
REQ-030 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR, increment each cycle mem_ready=0 in those states.
REQ-031 Counter reaching MEM_TIMEOUT with mem_ready=0 SHALL -> TRAP, cause 2; mem_ready in the same cycle wins over timeout.
REQ-032 TRAP: all enables and mem_req 0, trap=1, stays until reset.
REQ-033 Counter SHALL saturate, never wrap.

Reset
REQ-034 Reset assertion SHALL immediately force FETCH, counter 0, trap=0, trap_cause=0, all enables 0, selects 0, alu_ctrl 0, independent of clk.
REQ-035 Reset mid-access SHALL abandon the access; first cycle after deassertion is FETCH with mem_req=1.

Structure
REQ-036 State encodings, opcode constants, ALU_CTRL codes and trap causes SHALL reside in shared package cu_pkg.
REQ-037 ALU control decode SHALL be sub-module alu_decoder (combinational: funct3, funct7_5, op class -> alu_ctrl).

Verification
REQ-038 Reset low, then R-type ADD, mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 only in cycle 4.
REQ-039 LOAD with mem_ready delayed 3 cycles in MEM_RD -> 6 non-FETCH cycles after fetch, RD_WB asserts result_src=1.
REQ-040 BEQ zero=1 -> pc_write=1 in BRANCH; BNE zero=1 -> pc_write=0.
REQ-041 opcode 0000000 -> TRAP, trap=1, trap_cause=1, mem_req held 0 for 20 cycles.
REQ-042 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles, trap_cause=2.
REQ-043 Reset pulsed low mid MEM_WR -> outputs zero asynchronously; next edge after release shows FETCH.
